// File: rtl/conv_layer_sched_if.sv
// Host/loader/MAC-array signal bundle for the layer scheduler.
// The master side is the host and its peers; the slave side is the scheduler.
interface conv_layer_sched_if #(
  parameter int AW = 4
);
  logic          cfg_wen;
  logic [AW-1:0] cfg_waddr;
  logic [31:0]   cfg_wdata;
  logic          sched_start;
  logic [AW:0]   layer_num;
  logic          wload_req;
  logic          wload_done;
  logic          conv_start;
  logic          conv_done;
  logic [7:0]    in_ch;
  logic [7:0]    out_ch;
  logic [15:0]   map_size;
  logic [AW-1:0] cur_layer;
  logic          busy;
  logic          sched_done;
  logic          err;

  modport master (
    output cfg_wen, cfg_waddr, cfg_wdata, sched_start, layer_num, wload_done, conv_done,
    input  wload_req, conv_start, in_ch, out_ch, map_size, cur_layer, busy, sched_done, err
  );

  modport slave (
    input  cfg_wen, cfg_waddr, cfg_wdata, sched_start, layer_num, wload_done, conv_done,
    output wload_req, conv_start, in_ch, out_ch, map_size, cur_layer, busy, sched_done, err
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Layer-level scheduler: walks a host-written descriptor table, driving weight loads
// and MAC-array conv runs one layer at a time.
module conv_layer_sched #(
  parameter int LAYER_MAX = 16,
  parameter int AW        = 4
) (
  input logic               clk,
  input logic               rst,
  conv_layer_sched_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    START,
    RUN,
    NEXT,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   desc_table [LAYER_MAX];
  logic [AW-1:0] idx, last_idx, idx_nx;
  logic [31:0]   desc_nx;
  logic [7:0]    in_ch_q, out_ch_q;
  logic [15:0]   map_size_q;
  logic          err_q;
  logic          start_ok, start_bad, last_layer, load_cfg;
  logic          wload_req_c, conv_start_c, busy_c, sched_done_c;

  assign start_ok   = bus.sched_start && (bus.layer_num != '0) &&
                      (bus.layer_num <= (AW+1)'(LAYER_MAX));
  assign start_bad  = bus.sched_start && !start_ok;
  assign last_layer = (idx == last_idx);
  assign idx_nx     = (state == IDLE) ? '0 : idx + 1'b1;
  assign desc_nx    = desc_table[idx_nx];
  assign load_cfg   = ((state == IDLE) && start_ok) || ((state == NEXT) && !last_layer);

  // Descriptor storage is deliberately not reset so a reset mid-run keeps the table.
  always_ff @(posedge clk) begin
    if (bus.cfg_wen && (state == IDLE))
      desc_table[bus.cfg_waddr] <= bus.cfg_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    wload_req_c  = 1'b0;
    conv_start_c = 1'b0;
    busy_c       = 1'b1;
    sched_done_c = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (start_ok) state_nx = LOAD_W;
      end
      LOAD_W: begin
        wload_req_c = 1'b1;
        if (bus.wload_done) state_nx = START;
      end
      START: begin
        conv_start_c = 1'b1;
        state_nx     = RUN;
      end
      RUN: begin
        if (bus.conv_done) state_nx = NEXT;
      end
      NEXT: begin
        state_nx = last_layer ? DONE : LOAD_W;
      end
      DONE: begin
        sched_done_c = 1'b1;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // last_idx holds num-1 so the AW-bit index never has to represent LAYER_MAX itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      last_idx   <= '0;
      in_ch_q    <= '0;
      out_ch_q   <= '0;
      map_size_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start_bad;
      if ((state == IDLE) && start_ok)
        last_idx <= AW'(bus.layer_num - 1'b1);
      if (load_cfg) begin
        idx        <= idx_nx;
        in_ch_q    <= desc_nx[7:0];
        out_ch_q   <= desc_nx[15:8];
        map_size_q <= desc_nx[31:16];
      end
    end
  end

  assign bus.wload_req  = wload_req_c;
  assign bus.conv_start = conv_start_c;
  assign bus.busy       = busy_c;
  assign bus.sched_done = sched_done_c;
  assign bus.err        = err_q;
  assign bus.in_ch      = in_ch_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.map_size   = map_size_q;
  assign bus.cur_layer  = idx;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Randomized scoreboard bench for conv_layer_sched: expected conv_start/sched_done/err
// events are queued from a table model and popped by an independent monitor.
module tb_conv_layer_sched;
  localparam int LMAX = 16;
  localparam int AW   = 4;
  localparam logic [1:0] EV_CONV = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cs_count = 0;
  bit   running = 1'b0;

  logic [31:0] tbl [LMAX];
  logic [37:0] exp_q [$];

  conv_layer_sched_if #(.AW(AW)) bus ();

  conv_layer_sched #(.LAYER_MAX(LMAX), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [1:0] kind, input logic [3:0] layer,
                                   input logic [31:0] data);
    exp_q.push_back({kind, layer, data});
  endfunction

  // Monitor: every output pulse must match the head of the expected-event queue.
  always @(negedge clk) begin
    logic [37:0] got;
    got = '0;
    if (!rst && (bus.conv_start || bus.sched_done || bus.err)) begin
      if (bus.conv_start) begin
        got = {EV_CONV, bus.cur_layer, bus.map_size, bus.out_ch, bus.in_ch};
        cs_count++;
      end else if (bus.sched_done) begin
        got = {EV_DONE, 36'h0};
      end else begin
        got = {EV_ERR, 36'h0};
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h expected none at %0t", got, $time);
      end else begin
        check("event", 64'(got), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [AW-1:0] a, input logic [31:0] d);
    bus.cfg_wen   = 1'b1;
    bus.cfg_waddr = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_wen = 1'b0;
    if (!running) tbl[a] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wload_req"},  64'(bus.wload_req),  0);
    check({tag, "_conv_start"}, 64'(bus.conv_start), 0);
    check({tag, "_busy"},       64'(bus.busy),       0);
    check({tag, "_sched_done"}, 64'(bus.sched_done), 0);
    check({tag, "_err"},        64'(bus.err),        0);
    check({tag, "_cfg"}, 64'({bus.cur_layer, bus.map_size, bus.out_ch, bus.in_ch}), 0);
  endtask

  task automatic illegal_start(input logic [AW:0] n);
    push_exp(EV_ERR, 4'h0, 32'h0);
    bus.sched_start = 1'b1;
    bus.layer_num   = n;
    tick();
    bus.sched_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("illegal_busy", 64'(bus.busy), 0);
      check("illegal_wload_req", 64'(bus.wload_req), 0);
      tick();
    end
  endtask

  task automatic run_layers(input int num, input bit inj, input int abort_at);
    logic [31:0] snap [LMAX];
    int cs0;
    snap = tbl;
    cs0  = cs_count;
    for (int i = 0; i < num; i++) push_exp(EV_CONV, 4'(i), snap[i]);
    push_exp(EV_DONE, 4'h0, 32'h0);
    running = 1'b1;
    bus.sched_start = 1'b1;
    bus.layer_num   = (AW+1)'(num);
    tick();
    bus.sched_start = 1'b0;
    for (int i = 0; i < num; i++) begin
      check("wload_req_rise", 64'(bus.wload_req), 1);
      check("layer_cfg", 64'({bus.cur_layer, bus.map_size, bus.out_ch, bus.in_ch}),
            64'({4'(i), snap[i]}));
      repeat ($urandom_range(0, 2)) begin
        if (inj) begin
          bus.conv_done   = 1'($urandom_range(0, 1));
          bus.sched_start = 1'($urandom_range(0, 1));
          bus.layer_num   = (AW+1)'($urandom_range(0, 31));
        end
        tick();
        bus.conv_done   = 1'b0;
        bus.sched_start = 1'b0;
        check("load_w_hold", 64'({bus.wload_req, bus.conv_start}), 64'(2'b10));
      end
      bus.wload_done = 1'b1;
      tick();
      bus.wload_done = 1'b0;
      check("conv_start_after_wload", 64'({bus.wload_req, bus.conv_start}), 64'(2'b01));
      tick();
      check("conv_start_one_cycle", 64'(bus.conv_start), 0);
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1 check_all_zero("abort");
        exp_q.delete();
        running = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check_all_zero("post_abort");
        return;
      end
      repeat ($urandom_range(0, 3)) begin
        if (inj) begin
          bus.wload_done  = 1'($urandom_range(0, 1));
          bus.sched_start = 1'($urandom_range(0, 1));
          bus.layer_num   = (AW+1)'($urandom_range(0, 31));
          bus.cfg_wen     = 1'b1;
          bus.cfg_waddr   = AW'(i + 1);
          bus.cfg_wdata   = 32'hFFFF_FFFF;
        end
        tick();
        bus.wload_done  = 1'b0;
        bus.sched_start = 1'b0;
        bus.cfg_wen     = 1'b0;
        check("run_hold", 64'({bus.busy, bus.wload_req, bus.conv_start}), 64'(3'b100));
      end
      bus.conv_done  = 1'b1;
      bus.wload_done = inj ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      bus.conv_done  = 1'b0;
      bus.wload_done = 1'b0;
      tick();
      if (i == num - 1) begin
        check("sched_done_pulse", 64'({bus.sched_done, bus.busy, bus.wload_req}), 64'(3'b110));
        tick();
        check("busy_drop", 64'({bus.busy, bus.sched_done}), 0);
        check("last_cfg_hold", 64'({bus.cur_layer, bus.map_size, bus.out_ch, bus.in_ch}),
              64'({4'(num - 1), snap[num-1]}));
      end
    end
    running = 1'b0;
    check("conv_start_count", 64'(cs_count - cs0), 64'(num));
  endtask

  initial begin
    bus.cfg_wen     = 1'b0;
    bus.cfg_waddr   = '0;
    bus.cfg_wdata   = '0;
    bus.sched_start = 1'b0;
    bus.layer_num   = '0;
    bus.wload_done  = 1'b0;
    bus.conv_done   = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < LMAX; i++) write_cfg(AW'(i), $urandom());
    write_cfg(4'd0, 32'h0040_2010);
    write_cfg(4'd1, 32'h0020_4020);
    run_layers(2, 1'b0, -1);

    illegal_start(5'd0);
    illegal_start(5'd17);
    illegal_start(5'd31);

    run_layers(2, 1'b1, -1);

    for (int r = 0; r < 5; r++) begin
      write_cfg(AW'($urandom_range(0, LMAX - 1)), $urandom());
      run_layers($urandom_range(1, LMAX), 1'b1, -1);
    end

    run_layers(LMAX, 1'b1, 3);
    run_layers(LMAX, 1'b0, -1);

    repeat (3) tick();
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
